// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, stall/redirect control, decode-side output slot.
// Latency: none, wires only.
// Backpressure: i_stall from the hazard unit holds the output slot. The request is gated or skidded inside fetch_unit.
//
// Ports (master = fetch_unit side):
//   i_stall, i_redirect, i_redirect_pc        control inputs from hazard/branch units
//   imem_req, imem_addr / imem_ack, imem_rdata instruction-memory handshake
//   o_valid, o_instr, o_pc, o_rs1, o_rs2       output slot towards decode
interface fetch_unit_if;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;

    modport master (
        input  i_stall, i_redirect, i_redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, o_valid, o_instr, o_pc, o_rs1, o_rs2
    );

    modport slave (
        output i_stall, i_redirect, i_redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, o_valid, o_instr, o_pc, o_rs1, o_rs2
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding word fetch, one-entry output slot, redirect flush.
// Latency: one cycle from imem_ack to o_valid. A zero-wait memory sustains one instruction per cycle.
// Backpressure: when i_stall is set on a full slot, the request is withheld; with FETCH_SKID_EN the word is caught in a skid entry instead.
//
// Ports: clk, rst (async, active-high); bus (fetch_unit_if.master): see interface header.
// Optional feature: define FETCH_SKID_EN for a one-entry skid buffer (data + pc) and the HOLD state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;    // address of the stale request being drained in DROP
    logic        valid_q, valid_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] opc_q, opc_nxt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        slot_free;
`ifdef FETCH_SKID_EN
    logic        skid_vld, skid_vld_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= 32'h0;
            valid_q   <= 1'b0;
            instr_q   <= 32'h0;
            opc_q     <= 32'h0;
`ifdef FETCH_SKID_EN
            skid_vld   <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
`endif
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
            valid_q   <= valid_nxt;
            instr_q   <= instr_nxt;
            opc_q     <= opc_nxt;
`ifdef FETCH_SKID_EN
            skid_vld   <= skid_vld_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        valid_nxt     = valid_q;
        instr_nxt     = instr_q;
        opc_nxt       = opc_q;
        req           = 1'b0;
        addr          = pc;
`ifdef FETCH_SKID_EN
        skid_vld_nxt   = skid_vld;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
`endif

        case (state)
`ifdef FETCH_SKID_EN
            REQ:  req = 1'b1;
`else
            // Withhold the request while a stalled slot could not accept the word.
            REQ:  req = !(valid_q && bus.i_stall);
`endif
            DROP: begin
                req  = 1'b1;
                addr = drop_addr;
            end
            default: req = 1'b0;
        endcase

        // An ack only counts while a request is actually being presented.
        ack       = bus.imem_ack && req;
        slot_free = !valid_q || !bus.i_stall;

        if (bus.i_redirect) begin
            pc_nxt    = bus.i_redirect_pc & 32'hFFFF_FFFC;
            valid_nxt = 1'b0;
`ifdef FETCH_SKID_EN
            skid_vld_nxt = 1'b0;
`endif
            // A request left hanging must be drained before the new stream starts.
            if (req && !bus.imem_ack) begin
                state_nxt = DROP;
                if (state != DROP) begin
                    drop_addr_nxt = pc;
                end
            end else begin
                state_nxt = REQ;
            end
        end else begin
            if (!bus.i_stall) begin
                valid_nxt = 1'b0;
            end
            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (ack) begin
                        pc_nxt = pc + 32'd4;
`ifdef FETCH_SKID_EN
                        if (slot_free) begin
                            valid_nxt = 1'b1;
                            instr_nxt = bus.imem_rdata;
                            opc_nxt   = pc;
                        end else begin
                            skid_vld_nxt   = 1'b1;
                            skid_instr_nxt = bus.imem_rdata;
                            skid_pc_nxt    = pc;
                            state_nxt      = HOLD;
                        end
`else
                        valid_nxt = 1'b1;
                        instr_nxt = bus.imem_rdata;
                        opc_nxt   = pc;
`endif
                    end
                end
                DROP: begin
                    if (ack) begin
                        state_nxt = REQ;
                    end
                end
                HOLD: begin
`ifdef FETCH_SKID_EN
                    if (!bus.i_stall) begin
                        valid_nxt    = 1'b1;
                        instr_nxt    = skid_instr;
                        opc_nxt      = skid_pc;
                        skid_vld_nxt = 1'b0;
                        state_nxt    = REQ;
                    end
`else
                    state_nxt = REQ;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = addr;
    assign bus.o_valid   = valid_q;
    assign bus.o_instr   = instr_q;
    assign bus.o_pc      = opc_q;
    assign bus.o_rs1     = instr_q[19:15];
    assign bus.o_rs2     = instr_q[24:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model tracks the fetch stream, the output slot, the skid entry and any stale in-flight request.
// The memory responder acks after a configurable number of request cycles. It also raises stray acks while no request is presented.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state
    bit          m_started;   // first edge after reset seen
    bit          m_valid;
    logic [31:0] m_instr, m_opc, m_pc;
    bit          m_skid;
    logic [31:0] m_skid_instr, m_skid_pc;
    bit          m_stale;     // in-flight request belongs to a flushed stream
    logic [31:0] m_stale_addr;

    int n_pass, n_total;
    int mem_lat, mem_cnt, spur_pct;
    bit rand_lat;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_valid = 1'b0; m_instr = 32'h0; m_opc = 32'h0; m_pc = RST_PC;
        m_skid = 1'b0; m_skid_instr = 32'h0; m_skid_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
    endtask

    function automatic bit m_req(input bit stall);
        if (!m_started) return 1'b0;
        if (m_stale) return 1'b1;
        if (m_skid) return 1'b0;
        return SKID ? 1'b1 : !(m_valid && stall);
    endfunction

    task automatic model_step(input bit stall, input bit redir, input logic [31:0] rpc,
                              input bit er, input bit raw_ack, input logic [31:0] rd);
        bit seen;
        seen = raw_ack && er;
        if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (redir) begin
            if (er && !raw_ack) begin
                if (!m_stale) begin m_stale = 1'b1; m_stale_addr = m_pc; end
            end else begin
                m_stale = 1'b0;
            end
            m_pc = rpc & 32'hFFFF_FFFC; m_valid = 1'b0; m_skid = 1'b0;
        end else if (m_stale) begin
            if (seen) m_stale = 1'b0;
            if (!stall) m_valid = 1'b0;
        end else if (m_skid) begin
            if (!stall) begin m_instr = m_skid_instr; m_opc = m_skid_pc; m_valid = 1'b1; m_skid = 1'b0; end
        end else if (seen) begin
            if (!m_valid || !stall) begin m_instr = rd; m_opc = m_pc; m_valid = 1'b1; end
            else begin m_skid = 1'b1; m_skid_instr = rd; m_skid_pc = m_pc; end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        check("o_valid", 32'(bus.o_valid), 32'(m_valid));
        check("o_pc", bus.o_pc, m_opc);
        check("o_instr", bus.o_instr, m_instr);
        check("o_rs1", 32'(bus.o_rs1), 32'(m_instr[19:15]));
        check("o_rs2", 32'(bus.o_rs2), 32'(m_instr[24:20]));
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc);
        bit er;
        bus.i_stall = stall; bus.i_redirect = redir; bus.i_redirect_pc = rpc;
        #1;
        er = m_req(stall);
        last_req = bus.imem_req; last_addr = bus.imem_addr;
        check("imem_req", 32'(bus.imem_req), 32'(er));
        if (er) check("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
        if (bus.imem_req) begin
            if (mem_cnt >= mem_lat) begin
                bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr); mem_cnt = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                bus.imem_ack = 1'b0; bus.imem_rdata = $urandom; mem_cnt++;
            end
        end else begin
            bus.imem_ack = ($urandom_range(0, 99) < spur_pct); bus.imem_rdata = $urandom;
        end
        model_step(stall, redir, rpc, er, bus.imem_ack, bus.imem_rdata);
        @(posedge clk); #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        #1;
        check("rst_o_valid", 32'(bus.o_valid), 32'h0);
        check("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check("rst_o_pc", bus.o_pc, 32'h0);
        check("rst_o_instr", bus.o_instr, 32'h0);
        model_reset();
        mem_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        mem_lat = 0; mem_cnt = 0; spur_pct = 0; rand_lat = 1'b0;
        rst = 1'b1;
        bus.i_stall = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        model_reset();
        @(posedge clk); #1;

        // zero-wait streaming from RESET_PC
        do_reset();
        cycle(0, 0, 0);
        check("idle_no_req", 32'(last_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            check("stream_pc", bus.o_pc, RST_PC + 32'(4 * i));
            check("stream_vld", 32'(bus.o_valid), 32'h1);
        end
        check("stream_instr", bus.o_instr, mem_word(32'h108));

        // delayed ack: address held four cycles, valid one cycle after ack
        do_reset();
        mem_lat = 3;
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            check("wait_addr", last_addr, 32'h100);
            check("wait_vld", 32'(bus.o_valid), (i == 3) ? 32'h1 : 32'h0);
        end
        check("wait_pc", bus.o_pc, 32'h100);
        mem_lat = 0;

        // two-cycle stall on 0x104
        do_reset();
        cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        check("pre_stall_pc", bus.o_pc, 32'h104);
        cycle(1, 0, 0);
        check("stall1_req", 32'(last_req), 32'(SKID));
        check("stall1_pc", bus.o_pc, 32'h104);
        cycle(1, 0, 0);
        check("stall2_req", 32'(last_req), 32'h0);
        check("stall2_pc", bus.o_pc, 32'h104);
        check("stall2_vld", 32'(bus.o_valid), 32'h1);
        cycle(0, 0, 0);
        check("release_pc", bus.o_pc, 32'h108);
        check("release_vld", 32'(bus.o_valid), 32'h1);

        // redirect while 0x108 is outstanding
        do_reset();
        cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        mem_lat = 2;
        cycle(0, 1, 32'h203);
        check("redir_old_addr", last_addr, 32'h108);
        check("redir_vld", 32'(bus.o_valid), 32'h0);
        cycle(0, 0, 0);
        check("drop_addr", last_addr, 32'h108);
        check("drop_vld", 32'(bus.o_valid), 32'h0);
        cycle(0, 0, 0);
        check("drop_ack_vld", 32'(bus.o_valid), 32'h0);
        mem_lat = 0;
        cycle(0, 0, 0);
        check("new_addr", last_addr, 32'h200);
        check("new_pc", bus.o_pc, 32'h200);
        check("new_instr", bus.o_instr, mem_word(32'h200));

        // redirect coincident with ack
        cycle(0, 1, 32'h300);
        check("coinc_vld", 32'(bus.o_valid), 32'h0);
        check("coinc_instr", bus.o_instr, mem_word(32'h200));
        cycle(0, 0, 0);
        check("coinc_addr", last_addr, 32'h300);
        check("coinc_pc", bus.o_pc, 32'h300);

        // pc wraps silently past 0xFFFF_FFFC
        cycle(0, 1, 32'hFFFF_FFFB);
        cycle(0, 0, 0);
        check("wrap_pc0", bus.o_pc, 32'hFFFF_FFF8);
        cycle(0, 0, 0);
        check("wrap_pc1", bus.o_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        check("wrap_pc2", bus.o_pc, 32'h0);

        // reset mid-request at 0x10C
        do_reset();
        cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
        bus.i_stall = 1'b0; bus.i_redirect = 1'b0;
        #1;
        check("pre_rst_addr", bus.imem_addr, 32'h10C);
        check("pre_rst_vld", 32'(bus.o_valid), 32'h1);
        do_reset();
        spur_pct = 100;
        cycle(0, 0, 0);
        check("post_rst_idle_vld", 32'(bus.o_valid), 32'h0);
        spur_pct = 0;
        cycle(0, 0, 0);
        check("post_rst_addr", last_addr, RST_PC);

        // randomized traffic
        rand_lat = 1'b1;
        spur_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, rpc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_stall  input  1  decode-stage stall from the hazard unit; 1 = hold the output slot.
REQ-005 i_redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 i_redirect_pc  input  32  redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  response valid; SHALL be sampled only while a request is outstanding.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 o_valid  output  1  output slot holds a valid instruction; drives the hazard unit's fetch-valid input.
REQ-012 o_instr, o_pc  output  32 each  fetched instruction and its address.
REQ-013 o_rs1, o_rs2  output  5 each  o_instr[19:15] and o_instr[24:20], combinational.

Function
REQ-014 FSM states SHALL be IDLE, REQ, DROP and HOLD; at most one memory request SHALL be outstanding.
REQ-015 IDLE -> REQ unconditionally on the first edge after reset release.
REQ-016 In REQ, imem_req = !(o_valid && i_stall) and imem_addr = pc; addr SHALL stay stable until ack.
REQ-017 On ack in REQ with the slot free (!o_valid || !i_stall): o_instr<=imem_rdata, o_pc<=pc, o_valid<=1, pc<=pc+4 (mod 2^32).
REQ-018 Fetch-to-output latency SHALL be 1 cycle from ack; zero-wait memory SHALL sustain one instruction per cycle.
REQ-019 Output slot: i_stall=1 && o_valid=1 holds o_instr/o_pc/o_valid unchanged; i_stall=0 with no new ack SHALL clear o_valid.
REQ-020 i_redirect SHALL take priority over every other event in the same cycle.
REQ-021 On i_redirect: pc<=i_redirect_pc, o_valid<=0 next edge; a same-cycle ack SHALL be discarded.
REQ-022 Redirect while request outstanding without ack -> DROP; otherwise -> REQ.
REQ-023 DROP: imem_req held at the old address until ack; returned data discarded; ack -> REQ at the new pc.
REQ-024 Redirect while in DROP SHALL update pc and remain in DROP.
REQ-025 pc+4 wrap from 32'hFFFF_FFFC to 0 SHALL occur silently.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, pc=RESET_PC, o_valid=0, o_instr=0, o_pc=0, imem_req=0, skid empty.
REQ-027 Reset mid-request SHALL abandon it; any ack in IDLE SHALL be ignored.

Configuration
REQ-028 Macro FETCH_SKID_EN SHALL enable a one-entry skid buffer (data+pc).
REQ-029 With FETCH_SKID_EN: in REQ, imem_req=1 regardless of i_stall; an ack into a stalled full slot goes to skid, state -> HOLD, pc<=pc+4.
REQ-030 With FETCH_SKID_EN: HOLD keeps imem_req=0; when i_stall=0, skid moves to the slot and the state returns to REQ; redirect clears the skid.
REQ-031 Without FETCH_SKID_EN: HOLD SHALL be unreachable and the REQ-016 gating SHALL apply.

Verification
REQ-032 Reset, RESET_PC=0x100, zero-wait ack, i_stall=0 -> o_pc 0x100, 0x104, 0x108 on consecutive cycles, o_valid=1 throughout.
REQ-033 Ack delayed 3 cycles -> imem_addr stable 0x100 for 4 cycles, o_valid=1 exactly one cycle after the ack.
REQ-034 i_stall=1 for 2 cycles with o_pc=0x104 -> outputs held; without skid, imem_req=0 during the stall; with FETCH_SKID_EN, 0x108 is skidded and presented the cycle after release.
REQ-035 Redirect to 0x203 while 0x108 outstanding, ack 2 cycles later -> data discarded, next imem_addr=0x200, o_valid=0 until 0x200 returns.
REQ-036 Redirect coincident with ack -> ack data never reaches o_instr; next imem_addr = target.
REQ-037 rst pulsed mid-request at pc 0x10C -> o_valid=0 at once; the first request after release is at RESET_PC.
